ec_scalar_mult_ctrl: RTL and testbench
======================================

Name: ec_scalar_mult_ctrl

Overview:
Sequencer for the shared EC point-arithmetic unit used by final_top for ECDSA key and signature work. It takes a 256-bit scalar k, range-checks it against the group order, and scans k MSB-first with left-to-right double-and-add. For each step it issues point-double and point-add commands over a start/done handshake and signals completion or error to the top-level FSM.

Parameters:
KEY_W, 256, scalar width in bits.
GROUP_N, 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141, group order; a valid k satisfies 1 <= k < GROUP_N.
TIMEOUT, 4096, maximum cycles to wait for pu_done before aborting.

Ports:
clk  in  1  system clock, all state changes on posedge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request; sampled only in IDLE.
scalar  in  KEY_W  scalar k; latched on the accepted start.
pu_start  out  1  one-cycle command pulse to the point unit.
pu_op  out  1  0 = double (acc := 2·acc), 1 = add (acc := acc + G); valid with pu_start.
pu_done  in  1  one-cycle completion pulse from the point unit.
acc_init  out  1  one-cycle pulse: the datapath loads acc := G.
busy  out  1  high from the accepted start until Done or error.
Done  out  1  one-cycle pulse: the result in acc is valid.
invalid_error  out  1  sticky error; cleared on the next accepted start.

Behaviour:
- Reset (asynchronous, any state): state = IDLE. busy, Done, pu_start, pu_op, acc_init and invalid_error all = 0. Latched scalar, bit index and timeout counter = 0. An in-flight point-unit operation is abandoned; a later pu_done is ignored.
- IDLE: when start = 1, latch scalar, set busy = 1, clear invalid_error, go to CHECK. start while busy is ignored.
- CHECK (1 cycle): if k == 0 or k >= GROUP_N, raise invalid_error and go to IDLE. Done stays 0, no commands are issued, and busy drops in the next cycle. Otherwise set idx = KEY_W-1 and go to SEEK.
- SEEK: examines one bit per cycle. If k[idx] == 0, decrement idx. If k[idx] == 1, pulse acc_init. Then, if idx == 0, go to FINISH; otherwise decrement idx and go to DBL. SEEK always finds a 1 because k != 0.
- DBL: pulse pu_start with pu_op = 0, clear the timeout counter, go to DBL_WAIT.
- DBL_WAIT: on pu_done, go to ADD if k[idx] == 1. Otherwise go to NEXT.
- ADD: pulse pu_start with pu_op = 1, clear the timeout counter, go to ADD_WAIT.
- ADD_WAIT: on pu_done, go to NEXT.
- NEXT: if idx == 0, go to FINISH. Otherwise decrement idx and go to DBL.
- FINISH: pulse Done, clear busy, go to IDLE.
- Timeout: in DBL_WAIT or ADD_WAIT, the counter increments every cycle while pu_done = 0. When it reaches TIMEOUT-1 without pu_done, raise invalid_error, clear busy and go to IDLE with no Done.
- pu_done received outside a WAIT state is ignored.
- Exactly one command is outstanding at a time. pu_start is never asserted in a WAIT state.
- Command counts for a valid k with MSB position m:
  - doubles = m
  - adds = popcount(k) - 1
- idx is an 8-bit down-counter. It never wraps, because termination is checked at idx == 0 before any decrement.
- Latency with zero-latency pu_done:
  - start to the first SEEK cycle = 2 cycles.
  - Done follows the last pu_done by 2 cycles (NEXT, then FINISH).

Test Plan:
- k = 1 → SEEK runs 256 cycles, one acc_init pulse, zero pu_start pulses, Done pulses once, invalid_error = 0.
- k = 0, and separately k = GROUP_N → invalid_error = 1 two cycles after start, no acc_init, no pu_start, no Done; the next valid start clears invalid_error.
- k = 5 with a point-unit model returning pu_done 3 cycles after pu_start → op sequence init, DBL, DBL, ADD; then Done; model acc equals 5·G.
- k = GROUP_N-1 → 255 doubles and popcount(k)-1 adds; model acc equals -G (same x as G, y = p - Gy).
- Model never asserts pu_done → invalid_error rises exactly TIMEOUT cycles after the first pu_start, busy = 0, no Done.
- Deassert reset_n during ADD_WAIT, then assert pu_done after release → all outputs 0 and the controller stays in IDLE. A new start with k = 3 then gives the sequence init, DBL, ADD, then Done.

Source files
------------

// File: rtl/ec_scalar_mult_ctrl_if.sv
// Handshake bundle between the scalar-multiply sequencer, the top-level FSM and the point unit.
// The master side is the sequencer itself; the slave side is its environment.
interface ec_scalar_mult_ctrl_if #(
    parameter int KEY_W = 256
);
    logic             start;
    logic [KEY_W-1:0] scalar;
    logic             pu_start;
    logic             pu_op;
    logic             pu_done;
    logic             acc_init;
    logic             busy;
    logic             Done;
    logic             invalid_error;

    modport master (
        input  start, scalar, pu_done,
        output pu_start, pu_op, acc_init, busy, Done, invalid_error
    );

    modport slave (
        output start, scalar, pu_done,
        input  pu_start, pu_op, acc_init, busy, Done, invalid_error
    );
endinterface

// File: rtl/ec_scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer: range-checks k, then drives point-double/point-add
// commands over a start/done handshake with a per-command timeout.
module ec_scalar_mult_ctrl #(
    parameter int               KEY_W   = 256,
    parameter logic [KEY_W-1:0] GROUP_N = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141,
    parameter int               TIMEOUT = 4096
) (
    input logic                   clk,
    input logic                   reset_n,
    ec_scalar_mult_ctrl_if.master bus
);
    localparam int               IDX_W    = $clog2(KEY_W);
    localparam int               TMO_W    = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(KEY_W - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_SEEK,
        S_DBL,
        S_DBL_WAIT,
        S_ADD,
        S_ADD_WAIT,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [KEY_W-1:0] k_q, k_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic [TMO_W-1:0] tmo_inc;
    logic             tmo_hit;
    logic             cur_bit;
    logic             pu_start_c, pu_op_c, acc_init_c, done_c;

    // NOTE: sequential state uses non-blocking assignments only; all decisions live in the comb block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // The abort fires on the cycle the counter would step onto TIMEOUT-1.
    assign tmo_inc = tmo_q + TMO_W'(1);
    assign tmo_hit = (tmo_inc == TMO_LAST);
    assign cur_bit = k_q[idx_q];

    // NOTE: every variable gets its default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        pu_start_c = 1'b0;
        pu_op_c    = 1'b0;
        acc_init_c = 1'b0;
        done_c     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    k_d     = bus.scalar;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (k_q == '0 || k_q >= GROUP_N) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = IDX_TOP;
                    state_d = S_SEEK;
                end
            end
            S_SEEK: begin
                if (cur_bit) begin
                    acc_init_c = 1'b1;
                    if (idx_q == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = S_DBL;
                    end
                end else if (idx_q != '0) begin
                    idx_d = idx_q - IDX_W'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DBL: begin
                pu_start_c = 1'b1;
                tmo_d      = '0;
                state_d    = S_DBL_WAIT;
            end
            S_DBL_WAIT: begin
                if (bus.pu_done) begin
                    state_d = cur_bit ? S_ADD : S_NEXT;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            S_ADD: begin
                pu_start_c = 1'b1;
                pu_op_c    = 1'b1;
                tmo_d      = '0;
                state_d    = S_ADD_WAIT;
            end
            S_ADD_WAIT: begin
                if (bus.pu_done) begin
                    state_d = S_NEXT;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            S_NEXT: begin
                if (idx_q == '0) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                    state_d = S_DBL;
                end
            end
            S_FINISH: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.pu_start      = pu_start_c;
    assign bus.pu_op         = pu_op_c;
    assign bus.acc_init      = acc_init_c;
    assign bus.Done          = done_c;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.invalid_error = err_q;
endmodule

// File: tb/tb_ec_scalar_mult_ctrl.sv
// Scoreboard bench for ec_scalar_mult_ctrl: a point-unit model tracks acc as a multiple of G
// modulo the group order, and a monitor checks each transaction when busy falls.
module tb_ec_scalar_mult_ctrl;
    localparam int           KEY_W   = 256;
    localparam logic [255:0] GROUP_N = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;
    localparam int           TIMEOUT = 4096;
    localparam int           PU_LAT  = 3;
    localparam logic [256:0] N_EXT   = {1'b0, GROUP_N};

    typedef struct {
        int           start_cyc;
        bit           exp_err;
        int           exp_done;
        int           exp_init;
        int           exp_dbl;
        int           exp_add;
        bit           chk_acc;
        logic [256:0] exp_acc;
        bit           chk_hist;
        logic [15:0]  exp_hist;
        int           lat_kind;   // 0 none, 1 start->Done, 2 start->error, 3 first pu_start->error
        int           exp_lat;
        bit           chk_tail;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ec_scalar_mult_ctrl_if #(.KEY_W(KEY_W)) bus ();

    ec_scalar_mult_ctrl #(
        .KEY_W  (KEY_W),
        .GROUP_N(GROUP_N),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    task automatic check(input string name, input logic [256:0] act, input logic [256:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int popc(input logic [255:0] v);
        int c = 0;
        for (int i = 0; i < 256; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic exp_t mk(input bit err, input int done, input int init, input int dbl, input int add);
        exp_t e;
        e.start_cyc = 0;
        e.exp_err   = err;
        e.exp_done  = done;
        e.exp_init  = init;
        e.exp_dbl   = dbl;
        e.exp_add   = add;
        e.chk_acc   = 1'b0;
        e.exp_acc   = '0;
        e.chk_hist  = 1'b0;
        e.exp_hist  = '0;
        e.lat_kind  = 0;
        e.exp_lat   = 0;
        e.chk_tail  = 1'b0;
        return e;
    endfunction

    // Point-unit model: acc is held as an integer multiple of G modulo the group order.
    bit           pu_never = 1'b0;
    int           pend = 0;
    bit           pend_op = 1'b0;
    logic [256:0] acc_m = '0;
    logic [256:0] t;

    always @(posedge clk) begin
        #1;
        bus.pu_done = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                bus.pu_done = 1'b1;
                t = pend_op ? acc_m + 257'd1 : acc_m << 1;
                if (t >= N_EXT) t = t - N_EXT;
                acc_m = t;
            end
        end
        if (bus.acc_init) acc_m = 257'd1;
        if (bus.pu_start) begin
            check("single_outstanding", 257'(pend), 257'd0);
            if (!pu_never) begin
                pend    = PU_LAT;
                pend_op = bus.pu_op;
            end
        end
    end

    // Monitor: counts events per transaction and scores it when busy falls.
    int          n_init, n_dbl, n_add, n_done;
    int          done_cyc, err_cyc, first_pus_cyc, last_done_cyc;
    logic [15:0] hist;
    bit          prev_busy = 1'b0;
    bit          prev_err = 1'b0;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (bus.busy && !prev_busy) begin
            n_init = 0; n_dbl = 0; n_add = 0; n_done = 0;
            done_cyc = -1; err_cyc = -1; first_pus_cyc = -1; last_done_cyc = -1;
            hist = '0;
        end
        if (bus.acc_init) begin
            n_init++;
            hist = {hist[13:0], 2'd1};
        end
        if (bus.pu_start) begin
            if (bus.pu_op) begin
                n_add++;
                hist = {hist[13:0], 2'd3};
            end else begin
                n_dbl++;
                hist = {hist[13:0], 2'd2};
            end
            if (first_pus_cyc < 0) first_pus_cyc = cyc;
        end
        if (bus.pu_done && bus.busy) last_done_cyc = cyc;
        if (bus.Done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (bus.invalid_error && !prev_err) err_cyc = cyc;
        if (!bus.busy && prev_busy) begin
            if (sb_q.size() == 0) begin
                check("unexpected_end", 257'd1, 257'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("invalid_error", 257'(bus.invalid_error), 257'(mon_e.exp_err));
                check("done_count", 257'(n_done), 257'(mon_e.exp_done));
                check("init_count", 257'(n_init), 257'(mon_e.exp_init));
                check("dbl_count", 257'(n_dbl), 257'(mon_e.exp_dbl));
                check("add_count", 257'(n_add), 257'(mon_e.exp_add));
                if (mon_e.chk_acc) check("acc_multiple", acc_m, mon_e.exp_acc);
                if (mon_e.chk_hist) check("op_sequence", 257'(hist), 257'(mon_e.exp_hist));
                case (mon_e.lat_kind)
                    1: check("start_to_done", 257'(done_cyc - mon_e.start_cyc), 257'(mon_e.exp_lat));
                    2: check("start_to_error", 257'(err_cyc - mon_e.start_cyc), 257'(mon_e.exp_lat));
                    3: check("pu_start_to_timeout", 257'(err_cyc - first_pus_cyc), 257'(mon_e.exp_lat));
                    default: ;
                endcase
                if (mon_e.chk_tail) check("last_pu_done_to_done", 257'(done_cyc - last_done_cyc), 257'd2);
            end
        end
        prev_busy = bus.busy;
        prev_err  = bus.invalid_error;
    end

    task automatic issue(input logic [255:0] k, input exp_t e);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.scalar  = k;
        e.start_cyc = cyc;
        sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check({"wait_", name}, 257'(sb_q.size()), 257'd0);
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic [255:0] k;
        int          n;
        logic        any_out;
        bit          saw_done;

        bus.start  = 1'b0;
        bus.scalar = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 257'(bus.busy), 257'd0);
        check("rst_done", 257'(bus.Done), 257'd0);
        check("rst_pu_start", 257'(bus.pu_start), 257'd0);
        check("rst_pu_op", 257'(bus.pu_op), 257'd0);
        check("rst_acc_init", 257'(bus.acc_init), 257'd0);
        check("rst_invalid_error", 257'(bus.invalid_error), 257'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // k = 1: full 256-cycle seek, one init, no commands.
        e = mk(1'b0, 1, 1, 0, 0);
        e.chk_acc = 1'b1; e.exp_acc = 257'd1;
        e.chk_hist = 1'b1; e.exp_hist = 16'h0001;
        e.lat_kind = 1; e.exp_lat = 258;
        issue(256'd1, e);
        wait_idle("k1");

        // Out-of-range scalars.
        e = mk(1'b1, 0, 0, 0, 0);
        e.lat_kind = 2; e.exp_lat = 2;
        issue(256'd0, e);
        wait_idle("k0");
        issue(GROUP_N, e);
        wait_idle("kN");

        // k = 5 (101b): init, DBL, DBL, ADD; a stray start mid-run must be ignored.
        e = mk(1'b0, 1, 1, 2, 1);
        e.chk_acc = 1'b1; e.exp_acc = 257'd5;
        e.chk_hist = 1'b1; e.exp_hist = 16'h006B;
        e.chk_tail = 1'b1;
        issue(256'd5, e);
        check("error_cleared_on_start", 257'(bus.invalid_error), 257'd0);
        repeat (10) @(negedge clk);
        bus.start  = 1'b1;
        bus.scalar = '0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle("k5");

        // k = N-1: 255 doubles, popcount-1 adds, result is -G.
        k = GROUP_N - 256'd1;
        e = mk(1'b0, 1, 1, 255, popc(k) - 1);
        e.chk_acc = 1'b1; e.exp_acc = N_EXT - 257'd1;
        e.chk_tail = 1'b1;
        issue(k, e);
        wait_idle("kNm1");

        // Point unit never answers.
        pu_never = 1'b1;
        e = mk(1'b1, 0, 1, 1, 0);
        e.lat_kind = 3; e.exp_lat = TIMEOUT;
        issue(256'd2, e);
        wait_idle("timeout");
        pu_never = 1'b0;

        // Reset during ADD_WAIT; the late pu_done must be ignored.
        e = mk(1'b0, 0, 1, 1, 1);
        issue(256'd3, e);
        n = 0;
        while (!(bus.pu_start && bus.pu_op) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reached_add", 257'(bus.pu_start && bus.pu_op), 257'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        any_out  = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any_out  = any_out | bus.busy | bus.Done | bus.pu_start | bus.pu_op |
                       bus.acc_init | bus.invalid_error;
            saw_done = saw_done | bus.pu_done;
        end
        check("late_pu_done_driven", 257'(saw_done), 257'd1);
        check("quiet_after_reset", 257'(any_out), 257'd0);
        wait_idle("reset_abort");

        e = mk(1'b0, 1, 1, 1, 1);
        e.chk_acc = 1'b1; e.exp_acc = 257'd3;
        e.chk_hist = 1'b1; e.exp_hist = 16'h001B;
        e.chk_tail = 1'b1;
        issue(256'd3, e);
        wait_idle("k3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
